// File: rtl/decode_stage_ctrl_pkg.sv
// Shared opcode map, legal-opcode mask and per-opcode control table for the decode stage.
package decode_stage_ctrl_pkg;

  localparam int unsigned OpMapW = 4;

  typedef enum logic [OpMapW-1:0] {
    OpAdd   = 4'h0,
    OpAddi  = 4'h1,
    OpSubi  = 4'h2,
    OpLoad  = 4'h3,
    OpStore = 4'h4,
    OpLdih  = 4'h5,
    OpJump  = 4'h6,
    OpJmpr  = 4'h7,
    OpBz    = 4'h8,
    OpBnz   = 4'h9,
    OpBn    = 4'hA,
    OpBnn   = 4'hB,
    OpBc    = 4'hC,
    OpBnc   = 4'hD,
    OpHalt  = 4'hE
  } opcode_e;

  // Bit n set means opcode n is defined; 4'hF is reserved.
  localparam logic [2**OpMapW-1:0] OpLegalMask = 16'h7FFF;

  typedef enum logic [1:0] {
    ImmNone,
    ImmShort,
    ImmLong,
    ImmHigh
  } imm_kind_e;

  typedef struct packed {
    logic      rs_used;
    logic      rt_used;
    logic      rs_hi;    // rs taken from the rd field position
    logic      rt_hi;    // rt taken from the rd field position
    logic      alusrc;
    logic      regwrite;
    logic      memtoreg;
    logic      memwrite;
    logic      branch;
    logic      jump;
    logic      is_halt;
    imm_kind_e imm_kind;
  } op_ctrl_t;

  function automatic op_ctrl_t op_ctrl(logic [OpMapW-1:0] op);
    op_ctrl_t c;
    c = '0;
    case (op)
      OpAdd: begin
        c.rs_used  = 1'b1;
        c.rt_used  = 1'b1;
        c.regwrite = 1'b1;
      end
      OpAddi, OpSubi: begin
        c.rs_used  = 1'b1;
        c.rs_hi    = 1'b1;
        c.regwrite = 1'b1;
        c.alusrc   = 1'b1;
        c.imm_kind = ImmLong;
      end
      OpLoad: begin
        c.rs_used  = 1'b1;
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
        c.alusrc   = 1'b1;
        c.imm_kind = ImmShort;
      end
      OpStore: begin
        c.rs_used  = 1'b1;
        c.rt_used  = 1'b1;
        c.rt_hi    = 1'b1;
        c.memwrite = 1'b1;
        c.alusrc   = 1'b1;
        c.imm_kind = ImmShort;
      end
      OpLdih: begin
        c.rs_used  = 1'b1;
        c.rs_hi    = 1'b1;
        c.regwrite = 1'b1;
        c.alusrc   = 1'b1;
        c.imm_kind = ImmHigh;
      end
      OpJump: begin
        c.jump     = 1'b1;
        c.alusrc   = 1'b1;
        c.imm_kind = ImmLong;
      end
      OpJmpr: begin
        c.rs_used  = 1'b1;
        c.rs_hi    = 1'b1;
        c.jump     = 1'b1;
        c.alusrc   = 1'b1;
        c.imm_kind = ImmLong;
      end
      OpBz, OpBnz, OpBn, OpBnn, OpBc, OpBnc: begin
        c.rs_used  = 1'b1;
        c.rs_hi    = 1'b1;
        c.branch   = 1'b1;
        c.alusrc   = 1'b1;
        c.imm_kind = ImmLong;
      end
      OpHalt: c.is_halt = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_stage_ctrl_if.sv
// Fetch-side and execute-side signals of the decode stage, viewed from the stage (slave)
// or from the surrounding pipeline (master).
interface decode_stage_ctrl_if #(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned OP_W    = 4,
  parameter int unsigned REG_AW  = 4,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned PC_W    = 16
);
  logic               if_valid;
  logic               if_ready;
  logic [INSTR_W-1:0] if_instr;
  logic [PC_W-1:0]    if_pc;
  logic               flush;

  logic               id_valid;
  logic               id_ready;
  logic [PC_W-1:0]    id_pc;
  logic [OP_W-1:0]    id_op;
  logic [REG_AW-1:0]  id_rs;
  logic [REG_AW-1:0]  id_rt;
  logic [REG_AW-1:0]  id_rd;
  logic [DATA_W-1:0]  id_imm;
  logic               id_alusrc;
  logic               id_regwrite;
  logic               id_memtoreg;
  logic               id_memwrite;
  logic               id_branch;
  logic               id_jump;

  logic               halted;
  logic               illegal_op;

  modport master (
    output if_valid, if_instr, if_pc, flush, id_ready,
    input  if_ready, id_valid, id_pc, id_op, id_rs, id_rt, id_rd, id_imm,
    input  id_alusrc, id_regwrite, id_memtoreg, id_memwrite, id_branch, id_jump,
    input  halted, illegal_op
  );

  modport slave (
    input  if_valid, if_instr, if_pc, flush, id_ready,
    output if_ready, id_valid, id_pc, id_op, id_rs, id_rt, id_rd, id_imm,
    output id_alusrc, id_regwrite, id_memtoreg, id_memwrite, id_branch, id_jump,
    output halted, illegal_op
  );
endinterface

// File: rtl/decode_stage_ctrl_instr_field_decode.sv
// Purely combinational instruction cracker: fields, extended immediate, strobes and use flags.
module decode_stage_ctrl_instr_field_decode
  import decode_stage_ctrl_pkg::*;
#(
  parameter int unsigned INSTR_W    = 16,
  parameter int unsigned OP_W       = 4,
  parameter int unsigned REG_AW     = 4,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned SIMM_W     = 4,
  parameter int unsigned LIMM_W     = 8,
  parameter bit          SIGNED_IMM = 1'b0
) (
  input  logic [INSTR_W-1:0] instr_i,
  output logic [OP_W-1:0]    op_o,
  output logic [REG_AW-1:0]  rs_o,
  output logic [REG_AW-1:0]  rt_o,
  output logic [REG_AW-1:0]  rd_o,
  output logic [DATA_W-1:0]  imm_o,
  output logic               rs_used_o,
  output logic               rt_used_o,
  output logic               alusrc_o,
  output logic               regwrite_o,
  output logic               memtoreg_o,
  output logic               memwrite_o,
  output logic               branch_o,
  output logic               jump_o,
  output logic               is_halt_o,
  output logic               is_illegal_o
);

  localparam int unsigned RdLsb = INSTR_W - OP_W - REG_AW;
  localparam int unsigned RsLsb = RdLsb - REG_AW;

  logic [OpMapW-1:0] op_map;
  logic [REG_AW-1:0] f_hi, f_mid, f_lo;
  logic [SIMM_W-1:0] simm;
  logic [LIMM_W-1:0] limm;
  op_ctrl_t          ctrl;

  always_comb begin
    op_o   = instr_i[INSTR_W-1 -: OP_W];
    op_map = OpMapW'(op_o);
    f_hi   = instr_i[RdLsb +: REG_AW];
    f_mid  = instr_i[RsLsb +: REG_AW];
    f_lo   = instr_i[REG_AW-1:0];
    simm   = instr_i[SIMM_W-1:0];
    limm   = instr_i[LIMM_W-1:0];
    ctrl   = op_ctrl(op_map);

    rd_o = f_hi;
    rs_o = ctrl.rs_hi ? f_hi : f_mid;
    rt_o = ctrl.rt_hi ? f_hi : f_lo;

    imm_o = '0;
    case (ctrl.imm_kind)
      ImmShort: imm_o = DATA_W'(simm);
      ImmLong: begin
        if (SIGNED_IMM) imm_o = {{(DATA_W-LIMM_W){limm[LIMM_W-1]}}, limm};
        else            imm_o = DATA_W'(limm);
      end
      ImmHigh: imm_o = DATA_W'({limm, {LIMM_W{1'b0}}});
      default: imm_o = '0;
    endcase

    rs_used_o    = ctrl.rs_used;
    rt_used_o    = ctrl.rt_used;
    alusrc_o     = ctrl.alusrc;
    regwrite_o   = ctrl.regwrite;
    memtoreg_o   = ctrl.memtoreg;
    memwrite_o   = ctrl.memwrite;
    branch_o     = ctrl.branch;
    jump_o       = ctrl.jump;
    is_halt_o    = ctrl.is_halt;
    is_illegal_o = ~OpLegalMask[op_map];
  end

endmodule

// File: rtl/decode_stage_ctrl.sv
// Registered decode stage: valid/ready handshake, load-use stall, flush, sticky halt and
// illegal-opcode reporting around the combinational field decoder.
module decode_stage_ctrl
  import decode_stage_ctrl_pkg::*;
#(
  parameter int unsigned INSTR_W    = 16,
  parameter int unsigned OP_W       = 4,
  parameter int unsigned REG_AW     = 4,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned SIMM_W     = 4,
  parameter int unsigned LIMM_W     = 8,
  parameter int unsigned PC_W       = 16,
  parameter bit          SIGNED_IMM = 1'b0
) (
  input logic               clk,
  input logic               rst,
  decode_stage_ctrl_if.slave bus
);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] imm;
    logic              alusrc;
    logic              regwrite;
    logic              memtoreg;
    logic              memwrite;
    logic              branch;
    logic              jump;
  } bundle_t;

  bundle_t bundle_d, bundle_q;
  logic    id_valid_d, id_valid_q;
  logic    halted_d, halted_q;
  logic    illegal_op_d, illegal_op_q;

  logic [OP_W-1:0]   dec_op;
  logic [REG_AW-1:0] dec_rs, dec_rt, dec_rd;
  logic [DATA_W-1:0] dec_imm;
  logic dec_rs_used, dec_rt_used, dec_alusrc, dec_regwrite, dec_memtoreg, dec_memwrite;
  logic dec_branch, dec_jump, dec_is_halt, dec_is_illegal;
  logic adv, hazard, if_ready, accept;

  decode_stage_ctrl_instr_field_decode #(
    .INSTR_W   (INSTR_W),
    .OP_W      (OP_W),
    .REG_AW    (REG_AW),
    .DATA_W    (DATA_W),
    .SIMM_W    (SIMM_W),
    .LIMM_W    (LIMM_W),
    .SIGNED_IMM(SIGNED_IMM)
  ) u_instr_field_decode (
    .instr_i     (bus.if_instr),
    .op_o        (dec_op),
    .rs_o        (dec_rs),
    .rt_o        (dec_rt),
    .rd_o        (dec_rd),
    .imm_o       (dec_imm),
    .rs_used_o   (dec_rs_used),
    .rt_used_o   (dec_rt_used),
    .alusrc_o    (dec_alusrc),
    .regwrite_o  (dec_regwrite),
    .memtoreg_o  (dec_memtoreg),
    .memwrite_o  (dec_memwrite),
    .branch_o    (dec_branch),
    .jump_o      (dec_jump),
    .is_halt_o   (dec_is_halt),
    .is_illegal_o(dec_is_illegal)
  );

  // A load in the output register whose rd feeds the incoming instruction costs one bubble.
  always_comb begin
    adv    = ~id_valid_q | bus.id_ready;
    hazard = id_valid_q & bundle_q.memtoreg & bus.if_valid &
             ((dec_rs_used & (dec_rs == bundle_q.rd)) | (dec_rt_used & (dec_rt == bundle_q.rd)));
    if_ready = ~rst & ~halted_q & ~bus.flush & adv & ~hazard;
    accept   = bus.if_valid & if_ready;
  end

  always_comb begin
    bundle_d     = bundle_q;
    id_valid_d   = id_valid_q;
    halted_d     = halted_q;
    illegal_op_d = 1'b0;
    if (bus.flush) begin
      id_valid_d = 1'b0;
    end else if (accept) begin
      if (dec_is_illegal) begin
        illegal_op_d = 1'b1;
        id_valid_d   = 1'b0;
      end else if (dec_is_halt) begin
        halted_d   = 1'b1;
        id_valid_d = 1'b0;
      end else begin
        id_valid_d = 1'b1;
        bundle_d   = '{pc: bus.if_pc, op: dec_op, rs: dec_rs, rt: dec_rt, rd: dec_rd,
                       imm: dec_imm, alusrc: dec_alusrc, regwrite: dec_regwrite,
                       memtoreg: dec_memtoreg, memwrite: dec_memwrite,
                       branch: dec_branch, jump: dec_jump};
      end
    end else if (adv) begin
      id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bundle_q     <= '0;
      id_valid_q   <= 1'b0;
      halted_q     <= 1'b0;
      illegal_op_q <= 1'b0;
    end else begin
      bundle_q     <= bundle_d;
      id_valid_q   <= id_valid_d;
      halted_q     <= halted_d;
      illegal_op_q <= illegal_op_d;
    end
  end

  always_comb begin
    bus.if_ready    = if_ready;
    bus.id_valid    = id_valid_q;
    bus.id_pc       = bundle_q.pc;
    bus.id_op       = bundle_q.op;
    bus.id_rs       = bundle_q.rs;
    bus.id_rt       = bundle_q.rt;
    bus.id_rd       = bundle_q.rd;
    bus.id_imm      = bundle_q.imm;
    bus.id_alusrc   = bundle_q.alusrc;
    bus.id_regwrite = bundle_q.regwrite;
    bus.id_memtoreg = bundle_q.memtoreg;
    bus.id_memwrite = bundle_q.memwrite;
    bus.id_branch   = bundle_q.branch;
    bus.id_jump     = bundle_q.jump;
    bus.halted      = halted_q;
    bus.illegal_op  = illegal_op_q;
  end

endmodule

// File: tb/tb_decode_stage_ctrl.sv
// Directed bench for decode_stage_ctrl; a second instance with SIGNED_IMM=1 shadows the stimulus.
module tb_decode_stage_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  decode_stage_ctrl_if bus   ();
  decode_stage_ctrl_if bus_s ();

  assign bus_s.if_valid = bus.if_valid;
  assign bus_s.if_instr = bus.if_instr;
  assign bus_s.if_pc    = bus.if_pc;
  assign bus_s.flush    = bus.flush;
  assign bus_s.id_ready = bus.id_ready;

  decode_stage_ctrl #(.SIGNED_IMM(1'b0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  decode_stage_ctrl #(.SIGNED_IMM(1'b1)) dut_s (
    .clk(clk),
    .rst(rst),
    .bus(bus_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] instr, input logic [15:0] pc);
    bus.if_valid = v;
    bus.if_instr = instr;
    bus.if_pc    = pc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.id_ready = 1'b1;
    bus.flush = 1'b0;
    drive(1'b1, 16'h0123, 16'h0010);
    tick();
    tick();
    n_checks++; if (bus.if_ready !== 1'b0) begin n_fail++; $display("FAIL reset_if_ready: got %b want 0", bus.if_ready); end
    n_checks++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid: got %b want 0", bus.id_valid); end
    n_checks++; if (bus.id_imm !== 16'h0) begin n_fail++; $display("FAIL reset_id_imm: got %h want 0000", bus.id_imm); end
    n_checks++; if (bus.halted !== 1'b0 || bus.illegal_op !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got halted=%b illegal=%b want 0 0", bus.halted, bus.illegal_op); end
    drive(1'b0, 16'h0, 16'h0);
    rst = 1'b0;
    #1;
    n_checks++; if (bus.if_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_if_ready: got %b want 1", bus.if_ready); end
  endtask

  task automatic test_addi();
    drive(1'b1, 16'h13F0, 16'h0100);
    #1;
    n_checks++; if (bus.if_ready !== 1'b1) begin n_fail++; $display("FAIL addi_if_ready: got %b want 1", bus.if_ready); end
    tick();
    drive(1'b0, 16'h0, 16'h0);
    n_checks++; if (bus.id_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %b want 1", bus.id_valid); end
    n_checks++; if (bus.id_rd !== 4'd3 || bus.id_rs !== 4'd3) begin n_fail++; $display("FAIL addi_regs: got rd=%0d rs=%0d want 3 3", bus.id_rd, bus.id_rs); end
    n_checks++; if (bus.id_imm !== 16'h00F0) begin n_fail++; $display("FAIL addi_imm_zext: got %h want 00f0", bus.id_imm); end
    n_checks++; if (bus_s.id_imm !== 16'hFFF0) begin n_fail++; $display("FAIL addi_imm_sext: got %h want fff0", bus_s.id_imm); end
    n_checks++; if ({bus.id_alusrc, bus.id_regwrite, bus.id_memtoreg, bus.id_memwrite} !== 4'b1100) begin n_fail++; $display("FAIL addi_strobes: got %b want 1100", {bus.id_alusrc, bus.id_regwrite, bus.id_memtoreg, bus.id_memwrite}); end
    n_checks++; if (bus.id_pc !== 16'h0100 || bus.id_op !== 4'h1) begin n_fail++; $display("FAIL addi_pc_op: got pc=%h op=%h want 0100 1", bus.id_pc, bus.id_op); end
    tick();
    n_checks++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain: got %b want 0", bus.id_valid); end
  endtask

  task automatic test_load_use();
    drive(1'b1, 16'h3204, 16'h0200);
    tick();
    drive(1'b1, 16'h0123, 16'h0201);
    #1;
    n_checks++; if (bus.id_memtoreg !== 1'b1 || bus.id_imm !== 16'h0004) begin n_fail++; $display("FAIL load_bundle: got memtoreg=%b imm=%h want 1 0004", bus.id_memtoreg, bus.id_imm); end
    n_checks++; if (bus.if_ready !== 1'b0) begin n_fail++; $display("FAIL load_use_stall: got %b want 0", bus.if_ready); end
    tick();
    n_checks++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL load_use_bubble: got %b want 0", bus.id_valid); end
    n_checks++; if (bus.if_ready !== 1'b1) begin n_fail++; $display("FAIL load_use_release: got %b want 1", bus.if_ready); end
    tick();
    drive(1'b0, 16'h0, 16'h0);
    n_checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 16'h0201) begin n_fail++; $display("FAIL load_use_issue: got valid=%b pc=%h want 1 0201", bus.id_valid, bus.id_pc); end
    n_checks++; if (bus.id_rs !== 4'd2 || bus.id_rt !== 4'd3 || bus.id_rd !== 4'd1) begin n_fail++; $display("FAIL add_regs: got rs=%0d rt=%0d rd=%0d want 2 3 1", bus.id_rs, bus.id_rt, bus.id_rd); end
    n_checks++; if (bus.id_imm !== 16'h0 || bus.id_alusrc !== 1'b0) begin n_fail++; $display("FAIL add_imm: got imm=%h alusrc=%b want 0000 0", bus.id_imm, bus.id_alusrc); end
    tick();
    drive(1'b1, 16'h3204, 16'h0210);
    tick();
    drive(1'b1, 16'h0153, 16'h0211);
    #1;
    n_checks++; if (bus.if_ready !== 1'b1) begin n_fail++; $display("FAIL no_hazard_ready: got %b want 1", bus.if_ready); end
    tick();
    drive(1'b0, 16'h0, 16'h0);
    n_checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 16'h0211) begin n_fail++; $display("FAIL no_hazard_issue: got valid=%b pc=%h want 1 0211", bus.id_valid, bus.id_pc); end
    tick();
  endtask

  task automatic test_stall();
    drive(1'b1, 16'h0456, 16'h0300);
    tick();
    bus.id_ready = 1'b0;
    drive(1'b1, 16'h1712, 16'h0301);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (bus.if_ready !== 1'b0) begin n_fail++; $display("FAIL stall_if_ready[%0d]: got %b want 0", i, bus.if_ready); end
      tick();
      n_checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 16'h0300 || {bus.id_rd, bus.id_rs, bus.id_rt} !== 12'h456) begin n_fail++; $display("FAIL stall_hold[%0d]: got valid=%b pc=%h regs=%h want 1 0300 456", i, bus.id_valid, bus.id_pc, {bus.id_rd, bus.id_rs, bus.id_rt}); end
    end
    bus.id_ready = 1'b1;
    #1;
    n_checks++; if (bus.if_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release: got %b want 1", bus.if_ready); end
    tick();
    drive(1'b0, 16'h0, 16'h0);
    n_checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 16'h0301 || bus.id_rd !== 4'd7 || bus.id_imm !== 16'h0012) begin n_fail++; $display("FAIL stall_next: got valid=%b pc=%h rd=%0d imm=%h want 1 0301 7 0012", bus.id_valid, bus.id_pc, bus.id_rd, bus.id_imm); end
    tick();
  endtask

  task automatic test_flush();
    drive(1'b1, 16'h0456, 16'h0400);
    tick();
    bus.id_ready = 1'b0;
    bus.flush = 1'b1;
    drive(1'b1, 16'h1712, 16'h0401);
    #1;
    n_checks++; if (bus.if_ready !== 1'b0) begin n_fail++; $display("FAIL flush_if_ready: got %b want 0", bus.if_ready); end
    tick();
    bus.flush = 1'b0;
    bus.id_ready = 1'b1;
    n_checks++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL flush_kill: got %b want 0", bus.id_valid); end
    tick();
    drive(1'b0, 16'h0, 16'h0);
    n_checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 16'h0401 || bus.id_rd !== 4'd7) begin n_fail++; $display("FAIL flush_refetch: got valid=%b pc=%h rd=%0d want 1 0401 7", bus.id_valid, bus.id_pc, bus.id_rd); end
    tick();
  endtask

  task automatic test_halt();
    bus.flush = 1'b1;
    drive(1'b1, 16'hE000, 16'h0500);
    tick();
    bus.flush = 1'b0;
    drive(1'b0, 16'h0, 16'h0);
    n_checks++; if (bus.halted !== 1'b0 || bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL halt_flushed: got halted=%b valid=%b want 0 0", bus.halted, bus.id_valid); end
    drive(1'b1, 16'hE000, 16'h0501);
    tick();
    drive(1'b1, 16'h0123, 16'h0502);
    #1;
    n_checks++; if (bus.halted !== 1'b1 || bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL halt_set: got halted=%b valid=%b want 1 0", bus.halted, bus.id_valid); end
    n_checks++; if (bus.if_ready !== 1'b0) begin n_fail++; $display("FAIL halt_if_ready: got %b want 0", bus.if_ready); end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    tick();
    n_checks++; if (bus.halted !== 1'b1 || bus.id_valid !== 1'b0 || bus.if_ready !== 1'b0) begin n_fail++; $display("FAIL halt_sticky: got halted=%b valid=%b ready=%b want 1 0 0", bus.halted, bus.id_valid, bus.if_ready); end
    rst = 1'b1;
    tick();
    n_checks++; if (bus.halted !== 1'b0 || bus.if_ready !== 1'b0) begin n_fail++; $display("FAIL halt_reset: got halted=%b ready=%b want 0 0", bus.halted, bus.if_ready); end
    rst = 1'b0;
    #1;
    n_checks++; if (bus.if_ready !== 1'b1) begin n_fail++; $display("FAIL halt_resume_ready: got %b want 1", bus.if_ready); end
    tick();
    drive(1'b0, 16'h0, 16'h0);
    n_checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 16'h0502) begin n_fail++; $display("FAIL halt_resume_issue: got valid=%b pc=%h want 1 0502", bus.id_valid, bus.id_pc); end
    tick();
  endtask

  task automatic test_illegal();
    drive(1'b1, 16'hF123, 16'h0600);
    tick();
    drive(1'b1, 16'h0123, 16'h0601);
    n_checks++; if (bus.illegal_op !== 1'b1 || bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL illegal_pulse: got illegal=%b valid=%b want 1 0", bus.illegal_op, bus.id_valid); end
    tick();
    drive(1'b0, 16'h0, 16'h0);
    n_checks++; if (bus.illegal_op !== 1'b0 || bus.halted !== 1'b0) begin n_fail++; $display("FAIL illegal_clear: got illegal=%b halted=%b want 0 0", bus.illegal_op, bus.halted); end
    n_checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 16'h0601 || bus.id_rd !== 4'd1 || bus.id_regwrite !== 1'b1) begin n_fail++; $display("FAIL illegal_next: got valid=%b pc=%h rd=%0d rw=%b want 1 0601 1 1", bus.id_valid, bus.id_pc, bus.id_rd, bus.id_regwrite); end
    tick();
  endtask

  initial begin
    bus.if_valid = 1'b0;
    bus.if_instr = '0;
    bus.if_pc    = '0;
    bus.flush    = 1'b0;
    bus.id_ready = 1'b1;
    test_reset();
    test_addi();
    test_load_use();
    test_stall();
    test_flush();
    test_halt();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
